// File: rtl/i2c_slave.sv
// Single-address I2C target clocked directly by SCL; ACKs its address and captures write bytes.
// Define I2C_SLAVE_READ_EN to add read transfers that shift the held byte back out.
module i2c_slave #(
   parameter int                ADDR_W     = 8,
   parameter logic [ADDR_W-1:0] SLAVE_ADDR = 8'h77
) (
   input  logic       scl,
   input  logic       rst,
   inout  wire        sda,
   output logic [7:0] out
);

   localparam int CW = ($clog2(ADDR_W + 2) > 4) ? $clog2(ADDR_W + 2) : 4;
   localparam logic [CW-1:0] ADDR_BITS = CW'(ADDR_W + 1);
   localparam logic [CW-1:0] BYTE_BITS = CW'(8);
   localparam logic [CW-1:0] LAST_BIT  = CW'(7);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK
`ifdef I2C_SLAVE_READ_EN
      , READ, READ_ACK
`endif
   } state_t;

   state_t          state;
   logic            sda_oe;
   logic            sda_pos;
   logic            restart;
   logic [CW-1:0]   cnt;
   logic [ADDR_W:0] shreg;
   logic            start_cond;
   logic            stop_cond;
`ifdef I2C_SLAVE_READ_EN
   logic            rw;
   logic [6:0]      tx;
   logic [3:0]      tcnt;
`endif

   assign sda = sda_oe ? 1'b0 : 1'bz;

   // SDA moving while SCL was high shows up as a mismatch between the two edges.
   assign start_cond = sda_pos & ~sda;
   assign stop_cond  = ~sda_pos & sda;

   // Rising edge: sample the line, shift frame bits, commit a finished write byte.
   always_ff @(posedge scl or negedge rst) begin
      if (!rst) begin
         sda_pos <= 1'b1;
         cnt     <= '0;
         shreg   <= '0;
         out     <= 8'h00;
      end else begin
         sda_pos <= sda;
         if (state == ADDR || state == WRITE) begin
            cnt   <= (restart ? '0 : cnt) + CW'(1);
            shreg <= {shreg[ADDR_W-1:0], sda};
            if (state == WRITE && cnt == LAST_BIT)
               out <= {shreg[6:0], sda};
         end else begin
            cnt <= '0;
         end
      end
   end

   // Falling edge: bus conditions first, then protocol state and the SDA driver.
   always_ff @(negedge scl or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         sda_oe  <= 1'b0;
         restart <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
         rw      <= 1'b0;
         tx      <= '0;
         tcnt    <= '0;
`endif
      end else begin
         restart <= 1'b0;
         if (start_cond) begin
            state   <= ADDR;
            sda_oe  <= 1'b0;
            restart <= 1'b1;
         end else if (stop_cond) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
         end else begin
            case (state)
               ADDR: begin
                  if (cnt == ADDR_BITS) begin
`ifdef I2C_SLAVE_READ_EN
                     if (shreg[ADDR_W:1] == SLAVE_ADDR) begin
                        state  <= ADDR_ACK;
                        sda_oe <= 1'b1;
                        rw     <= shreg[0];
                     end else begin
                        state  <= IDLE;
                        sda_oe <= 1'b0;
                     end
`else
                     if (shreg[ADDR_W:1] == SLAVE_ADDR && !shreg[0]) begin
                        state  <= ADDR_ACK;
                        sda_oe <= 1'b1;
                     end else begin
                        state  <= IDLE;
                        sda_oe <= 1'b0;
                     end
`endif
                  end
               end
               ADDR_ACK: begin
                  state  <= WRITE;
                  sda_oe <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
                  if (rw) begin
                     state  <= READ;
                     sda_oe <= ~out[7];
                     tx     <= out[6:0];
                     tcnt   <= 4'd1;
                  end
`endif
               end
               WRITE: begin
                  if (cnt == BYTE_BITS) begin
                     state  <= WRITE_ACK;
                     sda_oe <= 1'b1;
                  end
               end
               WRITE_ACK: begin
                  state  <= WRITE;
                  sda_oe <= 1'b0;
               end
`ifdef I2C_SLAVE_READ_EN
               READ: begin
                  if (tcnt == 4'd8) begin
                     state  <= READ_ACK;
                     sda_oe <= 1'b0;
                  end else begin
                     sda_oe <= ~tx[6];
                     tx     <= {tx[5:0], 1'b0};
                     tcnt   <= tcnt + 4'd1;
                  end
               end
               // sda_pos holds the master's ACK bit sampled on the last rising edge.
               READ_ACK: begin
                  if (!sda_pos) begin
                     state  <= READ;
                     sda_oe <= ~out[7];
                     tx     <= out[6:0];
                     tcnt   <= 4'd1;
                  end else begin
                     state  <= IDLE;
                     sda_oe <= 1'b0;
                  end
               end
`endif
               default: begin
                  state  <= IDLE;
                  sda_oe <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bus-level bench for i2c_slave: bit-banged master on a pulled-up open-drain SDA.
module tb_i2c_slave;

   logic       scl;
   logic       rst;
   logic       m_sda;
   wire        sda;
   logic [7:0] out;
   int         n_chk;
   int         n_fail;

   assign sda = m_sda ? 1'bz : 1'b0;
   pullup (sda);

   i2c_slave dut (
      .scl (scl),
      .rst (rst),
      .sda (sda),
      .out (out)
   );

   // One SCL cycle: master puts b on the line (1 = release), s = line value mid-high.
   task automatic bit_io(input logic b, output logic s);
      m_sda = b;
      #5 scl = 1'b1;
      #4 s = sda;
      #4 scl = 1'b0;
      #2;
   endtask

   // The slave only sees conditions on the falling edge, so each one closes with an SCL pulse.
   task automatic start_c();
      m_sda = 1'b1;
      #5 scl = 1'b1;
      #4 m_sda = 1'b0;
      #4 scl = 1'b0;
      #2;
   endtask

   task automatic stop_c();
      m_sda = 1'b0;
      #5 scl = 1'b1;
      #4 m_sda = 1'b1;
      #4 scl = 1'b0;
      #2;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) bit_io(b[i], s);
   endtask

   task automatic addr_frame(input logic [7:0] a, input logic rw);
      logic s;
      send_byte(a);
      bit_io(rw, s);
   endtask

   task automatic reset_pulse();
      rst = 1'b0;
      #5 rst = 1'b1;
      #5;
   endtask

   task automatic test_reset();
      scl = 1'b0; m_sda = 1'b1; rst = 1'b0;
      #3;
      n_chk++;
      if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b want 1", sda); end
      n_chk++;
      if (out !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %h want 00", out); end
      #2 rst = 1'b1;
      #5;
   endtask

   task automatic test_write_single();
      logic s;
      start_c();
      addr_frame(8'h77, 1'b0);
      bit_io(1'b1, s);
      n_chk++;
      if (s !== 1'b0) begin n_fail++; $display("FAIL t1_addr_ack: got %b want 0", s); end
      for (int i = 7; i >= 1; i--) bit_io(((8'h55 >> i) & 8'h01) != 0, s);
      n_chk++;
      if (out !== 8'h00) begin n_fail++; $display("FAIL t1_out_partial: got %h want 00", out); end
      bit_io(1'b1, s);
      n_chk++;
      if (out !== 8'h55) begin n_fail++; $display("FAIL t1_out: got %h want 55", out); end
      bit_io(1'b1, s);
      n_chk++;
      if (s !== 1'b0) begin n_fail++; $display("FAIL t1_data_ack: got %b want 0", s); end
      stop_c();
      #1;
      n_chk++;
      if (sda !== 1'b1) begin n_fail++; $display("FAIL t1_sda_after_stop: got %b want 1", sda); end
      n_chk++;
      if (out !== 8'h55) begin n_fail++; $display("FAIL t1_out_after_stop: got %h want 55", out); end
   endtask

   task automatic test_nack();
      logic s;
      reset_pulse();
      start_c();
      addr_frame(8'h12, 1'b0);
      bit_io(1'b1, s);
      n_chk++;
      if (s !== 1'b1) begin n_fail++; $display("FAIL t2_addr_nack: got %b want 1", s); end
      send_byte(8'hA5);
      bit_io(1'b1, s);
      n_chk++;
      if (s !== 1'b1) begin n_fail++; $display("FAIL t2_data_nack: got %b want 1", s); end
      n_chk++;
      if (out !== 8'h00) begin n_fail++; $display("FAIL t2_out: got %h want 00", out); end
      stop_c();
   endtask

   task automatic test_back_to_back();
      logic s;
      start_c();
      addr_frame(8'h77, 1'b0);
      bit_io(1'b1, s);
      n_chk++;
      if (s !== 1'b0) begin n_fail++; $display("FAIL t3_addr_ack: got %b want 0", s); end
      send_byte(8'hA5);
      n_chk++;
      if (out !== 8'hA5) begin n_fail++; $display("FAIL t3_out0: got %h want a5", out); end
      bit_io(1'b1, s);
      n_chk++;
      if (s !== 1'b0) begin n_fail++; $display("FAIL t3_ack0: got %b want 0", s); end
      send_byte(8'h3C);
      n_chk++;
      if (out !== 8'h3C) begin n_fail++; $display("FAIL t3_out1: got %h want 3c", out); end
      bit_io(1'b1, s);
      n_chk++;
      if (s !== 1'b0) begin n_fail++; $display("FAIL t3_ack1: got %b want 0", s); end
      stop_c();
   endtask

   task automatic test_reset_midframe();
      logic s;
      start_c();
      addr_frame(8'h77, 1'b0);
      bit_io(1'b1, s);
      bit_io(1'b1, s); bit_io(1'b0, s); bit_io(1'b1, s);
      // 4th data bit: reset lands while SCL is high and stays low past the falling edge
      m_sda = 1'b0;
      #5 scl = 1'b1;
      #3 rst = 1'b0;
      #1;
      n_chk++;
      if (sda !== 1'b0) begin n_fail++; $display("FAIL t4_line_master_low: got %b want 0", sda); end
      n_chk++;
      if (out !== 8'h00) begin n_fail++; $display("FAIL t4_out_reset: got %h want 00", out); end
      #3 scl = 1'b0;
      #2 rst = 1'b1;
      bit_io(1'b0, s); bit_io(1'b1, s); bit_io(1'b0, s); bit_io(1'b1, s);
      bit_io(1'b1, s);
      n_chk++;
      if (s !== 1'b1) begin n_fail++; $display("FAIL t4_ignored_ack: got %b want 1", s); end
      addr_frame(8'h77, 1'b0);
      bit_io(1'b1, s);
      n_chk++;
      if (s !== 1'b1) begin n_fail++; $display("FAIL t4_no_start_ack: got %b want 1", s); end
      send_byte(8'hFF);
      n_chk++;
      if (out !== 8'h00) begin n_fail++; $display("FAIL t4_out_ignored: got %h want 00", out); end
      // Reset while the slave is pulling the ACK low must free the line at once
      start_c();
      addr_frame(8'h77, 1'b0);
      m_sda = 1'b1;
      #5 scl = 1'b1;
      #4 s = sda;
      n_chk++;
      if (s !== 1'b0) begin n_fail++; $display("FAIL t4_ack_before_rst: got %b want 0", s); end
      rst = 1'b0;
      #1;
      n_chk++;
      if (sda !== 1'b1) begin n_fail++; $display("FAIL t4_rst_release: got %b want 1", sda); end
      #3 scl = 1'b0;
      #2 rst = 1'b1;
      stop_c();
   endtask

   task automatic test_repeated_start();
      logic s;
      start_c();
      addr_frame(8'h77, 1'b0);
      bit_io(1'b1, s);
      bit_io(1'b1, s); bit_io(1'b1, s); bit_io(1'b0, s);
      start_c();
      n_chk++;
      if (out !== 8'h00) begin n_fail++; $display("FAIL t5_out_before: got %h want 00", out); end
      addr_frame(8'h77, 1'b0);
      bit_io(1'b1, s);
      n_chk++;
      if (s !== 1'b0) begin n_fail++; $display("FAIL t5_reack: got %b want 0", s); end
      send_byte(8'h0F);
      n_chk++;
      if (out !== 8'h0F) begin n_fail++; $display("FAIL t5_out: got %h want 0f", out); end
      bit_io(1'b1, s);
      n_chk++;
      if (s !== 1'b0) begin n_fail++; $display("FAIL t5_data_ack: got %b want 0", s); end
      stop_c();
   endtask

   task automatic test_read();
      logic       s;
      logic [7:0] exp_b;
      exp_b = 8'h55;
      start_c();
      addr_frame(8'h77, 1'b0);
      bit_io(1'b1, s);
      send_byte(exp_b);
      bit_io(1'b1, s);
      stop_c();
      n_chk++;
      if (out !== 8'h55) begin n_fail++; $display("FAIL t6_out: got %h want 55", out); end
      start_c();
      addr_frame(8'h77, 1'b1);
      bit_io(1'b1, s);
`ifdef I2C_SLAVE_READ_EN
      n_chk++;
      if (s !== 1'b0) begin n_fail++; $display("FAIL t6_read_ack: got %b want 0", s); end
      for (int i = 7; i >= 0; i--) begin
         bit_io(1'b1, s);
         n_chk++;
         if (s !== exp_b[i]) begin n_fail++; $display("FAIL t6_read_bit%0d: got %b want %b", i, s, exp_b[i]); end
      end
      bit_io(1'b1, s);
      n_chk++;
      if (s !== 1'b1) begin n_fail++; $display("FAIL t6_nack_slot: got %b want 1", s); end
      bit_io(1'b1, s);
      n_chk++;
      if (s !== 1'b1) begin n_fail++; $display("FAIL t6_idle_after_nack: got %b want 1", s); end
`else
      n_chk++;
      if (s !== 1'b1) begin n_fail++; $display("FAIL t6_read_nack: got %b want 1", s); end
      for (int i = 0; i < 8; i++) bit_io(1'b1, s);
      bit_io(1'b1, s);
      n_chk++;
      if (s !== 1'b1) begin n_fail++; $display("FAIL t6_read_idle: got %b want 1", s); end
`endif
      stop_c();
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      test_reset();
      test_write_single();
      test_nack();
      test_back_to_back();
      test_reset_midframe();
      test_repeated_start();
      test_read();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
